// File: rtl/bcd_display_scheduler_if.sv
// Display scheduler bus: producer controls, decoder loop and HEX outputs.
// slave = scheduler side, master = producer/decoder side.
interface bcd_display_scheduler_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_bcd;
  logic                    blank_lead;
  logic [6:0]              leds_in;
  logic [3:0]              bcd_out;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic                    busy;
  logic                    frame_done;
  logic                    code_err;

  modport master (
    output enable, load, value_bcd,
    output blank_lead, leds_in,
    input  bcd_out, hex_out, busy,
    input  frame_done, code_err
  );

  modport slave (
    input  enable, load, value_bcd,
    input  blank_lead, leds_in,
    output bcd_out, hex_out, busy,
    output frame_done, code_err
  );
endinterface

// File: rtl/bcd_display_scheduler.sv
// Time-shares one BCD-to-7-seg decoder over NUM_DIGITS positions.
// MSB-first scan, leading-zero and invalid-code blanking, tear-free.
module bcd_display_scheduler #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic                   clk,
  input logic                   rst_n,
  bcd_display_scheduler_if.slave bus
);
  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] BLANK = 4'd13;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [IW-1:0]           idx;
  logic                    zflag;
  logic [3:0]              code;
  logic [3:0]              mapped;
  logic                    start;
  logic                    last;
  logic                    bad;
  logic                    suppress;
  logic [3:0]              bcd_q;
  logic [7*NUM_DIGITS-1:0] hex_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  assign bus.bcd_out    = bcd_q;
  assign bus.hex_out    = hex_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.code_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!bus.enable) begin
      cnt <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (bus.load) begin
      pending <= bus.value_bcd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = DRIVE;
      DRIVE:   state_nx = CAPTURE;
      CAPTURE: state_nx = last ? IDLE : DRIVE;
      default: state_nx = IDLE;
    endcase
  end

  // Suppression and invalid codes are exclusive: one needs 0, one >13.
  always_comb begin
    start    = bus.enable && (cnt == '0);
    last     = (idx == '0);
    code     = shadow[int'(idx)*4 +: 4];
    bad      = (code > BLANK);
    suppress = zflag && (code == 4'd0) && !last;
    mapped   = code;
    unique case (1'b1)
      bad:      mapped = BLANK;
      suppress: mapped = BLANK;
      default:  mapped = code;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      idx    <= '0;
      zflag  <= 1'b0;
      bcd_q  <= BLANK;
      hex_q  <= '1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shadow <= pending;
            idx    <= IW'(NUM_DIGITS - 1);
            zflag  <= bus.blank_lead;
            busy_q <= 1'b1;
          end
        end
        DRIVE: begin
          bcd_q <= mapped;
          if (code != 4'd0) zflag <= 1'b0;
          if (bad) err_q <= 1'b1;
        end
        CAPTURE: begin
          hex_q[int'(idx)*7 +: 7] <= bus.leds_in;
          if (last) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench: stimulus queues per-frame expectations,
// a monitor pops and compares on every frame_done.
module tb_bcd_display_scheduler;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'h7F;

  typedef struct {
    logic [27:0] hex;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t e;

  bcd_display_scheduler_if #(.NUM_DIGITS(4)) bus ();

  bcd_display_scheduler #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(16)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [6:0] seg(input logic [3:0] c);
    case (c)
      4'd0:    return S0;
      4'd1:    return S1;
      4'd2:    return S2;
      4'd3:    return S3;
      4'd4:    return S4;
      4'd5:    return S5;
      4'd6:    return S6;
      4'd7:    return S7;
      4'd8:    return S8;
      4'd9:    return S9;
      4'd10:   return 7'b0001000;
      4'd11:   return 7'b1100000;
      4'd12:   return 7'b0110001;
      default: return SB;
    endcase
  endfunction

  always_comb bus.leds_in = seg(bus.bcd_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.frame_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_frame: got frame_done expected none");
      end else begin
        e = q.pop_front();
        chk("frame_hex", 32'(bus.hex_out), 32'(e.hex));
        chk("frame_err", 32'(bus.code_err), 32'(e.err));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [27:0] h, input logic er);
    exp_t x;
    x.hex = h;
    x.err = er;
    q.push_back(x);
  endtask

  task automatic load_val(input logic [15:0] v, input logic bl);
    bus.value_bcd  = v;
    bus.blank_lead = bl;
    bus.load       = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic start_frame(input logic [27:0] h, input logic er);
    push(h, er);
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.frame_done && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_done expected one");
    end
  endtask

  initial begin
    int n;
    int b;
    rst_n          = 1'b1;
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.value_bcd  = '0;
    bus.blank_lead = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    chk("rst_hex", 32'(bus.hex_out), 32'h0FFF_FFFF);
    chk("rst_bcd", 32'(bus.bcd_out), 32'd13);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_err", 32'(bus.code_err), 32'd0);
    rst_n = 1'b1;
    tick();

    load_val(16'h1234, 1'b0);
    push({S1, S2, S3, S4}, 1'b0);
    push({S1, S2, S3, S4}, 1'b0);
    bus.enable = 1'b1;
    wait_done();
    n = 0;
    b = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy) b++;
    end while (!bus.frame_done && n < 40);
    chk("frame_period", 32'(n), 32'd16);
    chk("busy_cycles", 32'(b), 32'd8);
    tick();
    bus.enable = 1'b0;
    tick();

    load_val(16'h0040, 1'b1);
    start_frame({SB, SB, S4, S0}, 1'b0);
    wait_done();
    tick();
    load_val(16'h0000, 1'b1);
    start_frame({SB, SB, SB, S0}, 1'b0);
    wait_done();
    tick();

    load_val(16'h1111, 1'b0);
    start_frame({S1, S1, S1, S1}, 1'b0);
    tick();
    load_val(16'h9999, 1'b0);
    wait_done();
    tick();
    start_frame({S9, S9, S9, S9}, 1'b0);
    wait_done();
    tick();

    load_val(16'h0567, 1'b0);
    push({S0, S5, S6, S7}, 1'b0);
    bus.enable = 1'b1;
    tick();
    tick(3);
    bus.enable = 1'b0;
    wait_done();
    tick(40);
    chk("drop_busy", 32'(bus.busy), 32'd0);
    chk("drop_hold", 32'(bus.hex_out),
        32'({S0, S5, S6, S7}));

    load_val(16'h1F23, 1'b0);
    start_frame({S1, SB, S2, S3}, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bad_bcd", 32'(bus.bcd_out), 32'd13);
    wait_done();
    tick();
    load_val(16'h1234, 1'b0);
    start_frame({S1, S2, S3, S4}, 1'b1);
    wait_done();
    tick();

    load_val(16'h4321, 1'b0);
    bus.enable = 1'b1;
    tick();
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hex", 32'(bus.hex_out), 32'h0FFF_FFFF);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_bcd", 32'(bus.bcd_out), 32'd13);
    chk("mid_rst_err", 32'(bus.code_err), 32'd0);
    tick(2);
    push({S0, S0, S0, S0}, 1'b0);
    rst_n = 1'b1;
    tick();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("first_digit3", 32'(bus.hex_out),
        32'({S0, SB, SB, SB}));
    wait_done();
    tick();
    bus.enable = 1'b0;
    tick(30);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
